// File: rtl/inst_fetcher_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetcher and the decoder.
package inst_fetcher_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HAVE,
    FS_STALL
  } fetch_state_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/inst_fetcher.sv
// Fetch stage: owns the PC, one outstanding
// imem request, hands words to the decoder.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic [XLEN-1:0] inst_out,
  output logic            inst_ready_out,
  output logic [XLEN-1:0] inst_addr_out,
  input  logic [XLEN-1:0] dec_next_pc,
  input  logic            dec_stall,
  input  logic            iq_full,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            clear_out
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic            drop_q, drop_d;
  logic            req_q, req_d;
  logic            req_hs;
  logic            in_flight;

  // Next-state, PC and latch control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    iaddr_d   = iaddr_q;
    drop_d    = drop_q;
    req_hs    = req_q && mem_req_ready;
    in_flight = 1'b0;
    if (rdy_in) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
        in_flight =
          (state_q == FS_WAIT && !mem_resp_valid) ||
          (state_q == FS_REQ && req_hs);
        if (in_flight) begin
          state_d = FS_WAIT;
          drop_d  = 1'b1;
        end else begin
          state_d = FS_REQ;
          drop_d  = 1'b0;
        end
      end else begin
        unique case (state_q)
          FS_REQ: begin
            if (req_hs) state_d = FS_WAIT;
          end
          FS_WAIT: begin
            if (mem_resp_valid) begin
              if (drop_q) begin
                drop_d  = 1'b0;
                state_d = FS_REQ;
              end else begin
                inst_d  = mem_resp_data;
                iaddr_d = pc_q;
                state_d = FS_HAVE;
              end
            end
          end
          FS_HAVE: begin
            if (!iq_full) begin
              if (dec_stall) begin
                state_d = FS_STALL;
              end else begin
                pc_d    = dec_next_pc;
                state_d = FS_REQ;
              end
            end
          end
          FS_STALL: begin
            state_d = FS_STALL;
          end
          default: state_d = FS_REQ;
        endcase
      end
    end
    req_d = rdy_in ? (state_d == FS_REQ) : req_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      iaddr_q <= '0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      iaddr_q <= iaddr_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
    end
  end

  assign mem_req_valid  = req_q;
  assign mem_req_addr   = pc_q;
  assign inst_out       = inst_q;
  assign inst_addr_out  = iaddr_q;
  assign inst_ready_out = (state_q == FS_HAVE);
  assign clear_out      = redirect_valid;

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage that owns the architectural fetch PC and issues one instruction-memory request at a time.
- Presents each fetched instruction, with its address, to the decoder one cycle after the memory response arrives.
- Takes the decoder's combinational next-PC and stall back, and applies them to the PC on acceptance.
- Handles commit-side redirects (clear) and backpressure from the instruction queue.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
XLEN, 32, address/instruction width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset (low = reset)
rdy_in  input  1  global ready; low freezes all state
mem_req_valid  output  1  instruction fetch request
mem_req_addr  output  XLEN  fetch address (word aligned)
mem_req_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  fetch data valid (one-cycle pulse)
mem_resp_data  input  XLEN  fetched instruction word
inst_out  output  XLEN  instruction to decoder and instruction queue
inst_ready_out  output  1  inst_out/inst_addr_out valid
inst_addr_out  output  XLEN  PC of inst_out
dec_next_pc  input  XLEN  decoder's predicted next PC (combinational from inst_out)
dec_stall  input  1  decoder requests fetch hold (JALR)
iq_full  input  1  instruction queue cannot accept this cycle
redirect_valid  input  1  commit-side flush/redirect
redirect_pc  input  XLEN  redirect target
clear_out  output  1  flush indication to decoder (= redirect_valid, combinational)

Behaviour:
- Reset (rst_in low, async): pc=RESET_PC, state=REQ, mem_req_valid=0, inst_ready_out=0, inst_out=0, inst_addr_out=0, drop=0.
- rdy_in low: no register changes; outputs hold their values.
- States:
  - REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready -> WAIT.
  - WAIT: no request. On mem_resp_valid -> latch inst_out=data, inst_addr_out=pc; go to HAVE. If drop=1, discard the response, clear drop, go to REQ.
  - HAVE: inst_ready_out=1. Accept = !iq_full. On accept: if dec_stall -> STALL with pc unchanged; else pc=dec_next_pc -> REQ. On !iq_full=0 (queue full): hold; inst_out is stable and dec_next_pc is ignored.
  - STALL: inst_ready_out=0, no requests. Leaves only via redirect.
- Latency:
  - Request issue to inst_ready_out: 1 cycle after mem_resp_valid.
  - Accept to next mem_req_valid: 1 cycle.
- Redirect has highest priority, from any state:
  - pc=redirect_pc and inst_ready_out drops next cycle.
  - From WAIT, or from REQ with mem_req_ready the same cycle (outstanding request): drop=1, go to WAIT so the stale response is discarded.
  - Otherwise go to REQ.
  - A same-cycle mem_resp_valid in WAIT counts as the outstanding response: discard it, go to REQ, drop=0.
  - A same-cycle accept in HAVE is cancelled; the redirect wins.
- Only one request is outstanding at a time.
- mem_req_addr[1:0] is always passed as given. Misalignment is not checked; redirect_pc is trusted.
- PC arithmetic is modulo 2^XLEN: wrap-around is permitted with no error.
- Reset asserted mid-request: the state machine returns to REQ immediately. Any later mem_resp_valid is ignored, because the machine is not in WAIT until a new request is accepted.

Decomposition:
- Shared package: XLEN, RESET_PC default, fetch state enum (REQ/WAIT/HAVE/STALL), opcode constants shared with the decoder.
- No sub-module. A single FSM plus registers is natural.
- Decoder stays a separate combinational block, instantiated at the top level.

Test Plan:
- Reset, then mem_req_ready=1 and resp 32'h00000013 at 0x0 one cycle later, iq_full=0 -> inst_ready_out for 1 cycle with addr 0x0; next request at 0x4.
- Fetch JAL 32'h0080006F at 0x10 -> dec_next_pc=0x18 applied; next mem_req_addr=0x18.
- Fetch JALR at 0x20 (dec_stall=1) -> STALL, no mem_req_valid for 20 cycles; redirect_valid with 0x100 -> next request at 0x100.
- iq_full=1 for 5 cycles while in HAVE -> inst_out/addr held and pc unchanged; iq_full=0 -> accept, pc updates once.
- Redirect to 0x200 while in WAIT, stale resp arrives 3 cycles later -> discarded (inst_ready_out stays 0); next request at 0x200, its response delivered.
- rdy_in low for 4 cycles mid-WAIT, then async rst_in low pulse -> state frozen during rdy low; after reset, pc=RESET_PC and outputs are zero.
